// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser and the vending FSM that drives it:
// state encoding, hopper coin codes, coin values and the item price.
package change_dispenser_pkg;

    localparam int PRICE_DEFAULT = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DROP,
        ST_PAY_REQ,
        ST_PAY_WAIT,
        ST_GAP,
        ST_DONE,
        ST_FAULT
    } state_t;

    localparam logic [1:0] COIN_SEL_NONE = 2'd0;
    localparam logic [1:0] COIN_SEL_1    = 2'd1;
    localparam logic [1:0] COIN_SEL_2    = 2'd2;
    localparam logic [1:0] COIN_SEL_5    = 2'd3;

    localparam logic [3:0] COIN_VAL_1 = 4'd1;
    localparam logic [3:0] COIN_VAL_2 = 4'd2;
    localparam logic [3:0] COIN_VAL_5 = 4'd5;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest coin not exceeding the outstanding change.
module change_dispenser_coin_select
    import change_dispenser_pkg::*;
(
    input  logic [3:0] change,
    output logic [1:0] coin_sel,
    output logic [3:0] coin_value
);

    always_comb begin
        coin_sel   = COIN_SEL_1;
        coin_value = COIN_VAL_1;
        if (change >= COIN_VAL_5) begin
            coin_sel   = COIN_SEL_5;
            coin_value = COIN_VAL_5;
        end else if (change >= COIN_VAL_2) begin
            coin_sel   = COIN_SEL_2;
            coin_value = COIN_VAL_2;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: drops the item, then pays change one hopper coin at a time.
//
// state     | meaning
// IDLE      | waiting for a payment-complete strobe
// DROP      | one-cycle item release
// PAY_REQ   | present the next greedy coin to the hopper, clear the ack timer
// PAY_WAIT  | hold the request until ack or timeout
// GAP       | request low for one cycle before the next coin
// DONE      | one-cycle completion pulse
// FAULT     | underpayment or hopper timeout, held until reset
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PRICE       = PRICE_DEFAULT,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [3:0] i_paid,
    input  logic       i_coin_ack,
    output logic       o_busy,
    output logic       o_item_drop,
    output logic       o_coin_req,
    output logic [1:0] o_coin_sel,
    output logic       o_done,
    output logic       o_fault
);

    localparam logic [3:0] PRICE_W   = 4'(PRICE);
    localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT);

    state_t     state, state_nx;
    logic [3:0] change, change_nx;
    logic [7:0] ack_cnt, ack_cnt_nx;
    logic [1:0] coin_sel;
    logic [3:0] coin_value;
    logic       req_nx;

    change_dispenser_coin_select u_coin_select (
        .change     (change),
        .coin_sel   (coin_sel),
        .coin_value (coin_value)
    );

    always_comb begin
        state_nx   = state;
        change_nx  = change;
        ack_cnt_nx = ack_cnt;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_paid >= PRICE_W) begin
                        change_nx = i_paid - PRICE_W;
                        state_nx  = ST_DROP;
                    end else begin
                        state_nx = ST_FAULT;
                    end
                end
            end
            ST_DROP:     state_nx = (change == 4'd0) ? ST_DONE : ST_PAY_REQ;
            ST_PAY_REQ: begin
                ack_cnt_nx = 8'd0;
                state_nx   = ST_PAY_WAIT;
            end
            ST_PAY_WAIT: begin
                ack_cnt_nx = ack_cnt + 8'd1;
                // an ack on the very cycle the limit is hit still wins
                if (i_coin_ack) begin
                    change_nx = change - coin_value;
                    state_nx  = ST_GAP;
                end else if (ack_cnt_nx == ACK_LIMIT) begin
                    state_nx = ST_FAULT;
                end
            end
            ST_GAP:      state_nx = (change == 4'd0) ? ST_DONE : ST_PAY_REQ;
            ST_DONE:     state_nx = ST_IDLE;
            ST_FAULT:    state_nx = ST_FAULT;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with the state register
    assign req_nx = (state_nx == ST_PAY_REQ) || (state_nx == ST_PAY_WAIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            change      <= 4'd0;
            ack_cnt     <= 8'd0;
            o_busy      <= 1'b0;
            o_item_drop <= 1'b0;
            o_coin_req  <= 1'b0;
            o_coin_sel  <= COIN_SEL_NONE;
            o_done      <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            state       <= state_nx;
            change      <= change_nx;
            ack_cnt     <= ack_cnt_nx;
            o_busy      <= (state_nx != ST_IDLE) && (state_nx != ST_FAULT);
            o_item_drop <= (state_nx == ST_DROP);
            o_coin_req  <= req_nx;
            o_coin_sel  <= req_nx ? coin_sel : COIN_SEL_NONE;
            o_done      <= (state_nx == ST_DONE);
            o_fault     <= (state_nx == ST_FAULT);
        end
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter PRICE, default 6: item price in CNY.
REQ-002 Parameter ACK_TIMEOUT, default 255: maximum cycles to wait for a hopper acknowledge.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 i_start  input  1  one-cycle strobe from the vending FSM: payment complete.
REQ-006 i_paid  input  4  total inserted CNY, 0..15; valid only while i_start=1.
REQ-007 o_busy  output  1  high from the cycle after an accepted i_start until return to IDLE.
REQ-008 o_item_drop  output  1  one-cycle pulse: release the item.
REQ-009 o_coin_req  output  1  hopper request, held until acknowledged.
REQ-010 o_coin_sel  output  2  coin to eject: 2'd1 = 1 CNY, 2'd2 = 2 CNY, 2'd3 = 5 CNY; 0 when o_coin_req=0.
REQ-011 i_coin_ack  input  1  hopper acknowledge: one coin ejected.
REQ-012 o_done  output  1  one-cycle pulse: transaction finished, change fully paid.
REQ-013 o_fault  output  1  sticky: underpayment or hopper timeout.

Function
REQ-014 FSM states: IDLE, DROP, PAY_REQ, PAY_WAIT, GAP, DONE, FAULT.
REQ-015 All outputs are registered; each output is a Moore decode of the current state and registers.
REQ-016 IDLE, i_start=1, i_paid>=PRICE: latch change = i_paid-PRICE (4-bit) and go to DROP.
REQ-017 IDLE, i_start=1, i_paid<PRICE: go to FAULT, with no item drop and no coin request.
REQ-018 i_start is ignored in every state except IDLE.
REQ-019 DROP: o_item_drop=1 for exactly one cycle.
REQ-020 DROP exit: go to DONE if change=0, else to PAY_REQ.
REQ-021 PAY_REQ: select the coin greedily: 5 if change>=5, else 2 if change>=2, else 1.
REQ-022 PAY_REQ: assert o_coin_req with o_coin_sel, clear the timeout counter, then go to PAY_WAIT.
REQ-023 PAY_WAIT: hold o_coin_req and o_coin_sel stable.
REQ-024 PAY_WAIT, on i_coin_ack=1: subtract the coin value from change, deassert req, go to GAP.
REQ-025 GAP: one cycle with o_coin_req=0 (return-to-zero handshake).
REQ-026 GAP exit: go to DONE if change=0, else to PAY_REQ.
REQ-027 i_coin_ack outside PAY_WAIT is ignored.
REQ-028 A timeout counter (8 bits) increments each cycle in PAY_WAIT.
REQ-029 Timeout counter reaching ACK_TIMEOUT without an ack: go to FAULT and drop o_coin_req.
REQ-030 An ack in the same cycle the counter reaches ACK_TIMEOUT counts as success.
REQ-031 DONE: o_done=1 for one cycle, then IDLE.
REQ-032 FAULT: o_fault=1 and o_busy=0, held until reset.
REQ-033 Change arithmetic is 4-bit unsigned and never underflows, because the greedy coin is always <= change.
REQ-034 Latency, i_paid=PRICE: i_start in cycle N gives o_item_drop in N+1 and o_done in N+2.
REQ-035 Latency per coin: minimum 3 cycles when the ack arrives on the first PAY_WAIT cycle.

Reset
REQ-036 rst=0 at a clock edge forces IDLE, change=0 and the counter to 0.
REQ-037 Reset drives every output to 0, o_fault included.
REQ-038 Reset mid-dispense abandons the remaining change, and no further request is issued.

Structure
REQ-039 The shared package holds the state encoding, the coin-select codes and the coin values (1/2/5).
REQ-040 The shared package holds the PRICE default, so the vending FSM and this block agree.
REQ-041 One sub-module is natural: change_coin_select, a combinational greedy selector mapping change[3:0] to coin_sel and coin_value.

Verification
REQ-042 Exact payment: i_paid=6 -> drop at N+1, done at N+2, o_coin_req never high.
REQ-043 Overpay with 2s: i_paid=10 -> drop, then coin_sel=2 acked, coin_sel=2 acked, then done.
REQ-044 Mixed change: i_paid=14 (change 8) -> coins 5, 2, 1 in that order, then done; GAP cycle with req=0 between each.
REQ-045 Underpay: i_paid=4 -> o_fault=1, o_item_drop never pulses, o_busy=0.
REQ-046 Timeout: i_paid=7 with i_coin_ack held 0 -> req drops and o_fault=1 after ACK_TIMEOUT PAY_WAIT cycles.
REQ-047 Reset mid-dispense: i_paid=11, reset asserted during PAY_WAIT -> all outputs 0 next cycle.
REQ-048 Ignored start: i_start while busy has no effect, and the next i_start after done is accepted normally.
